// File: rtl/ir_fetch_if.sv
// Signal bundle between ir_fetch_ctrl and its neighbours: host loader, decode
// stage and the IR memory. master = controller side, slave = environment side.
interface ir_fetch_if #(
  parameter int IR_WIDTH     = 16,
  parameter int IR_MEM_WIDTH = 4
);
  logic                    load_start;
  logic                    load_valid;
  logic [IR_WIDTH-1:0]     load_data;
  logic                    load_last;
  logic                    load_ready;
  logic                    run_start;
  logic                    halt_req;
  logic                    br_valid;
  logic [IR_MEM_WIDTH-1:0] br_target;
  logic                    inst_valid;
  logic [IR_WIDTH-1:0]     inst_data;
  logic [IR_MEM_WIDTH-1:0] inst_pc;
  logic                    inst_ready;
  logic [IR_MEM_WIDTH-1:0] ir_addr;
  logic [IR_WIDTH-1:0]     ir_wdata;
  logic                    ir_we;
  logic [IR_WIDTH-1:0]     ir_rdata;
  logic [IR_MEM_WIDTH:0]   prog_len;
  logic [2:0]              state;
  logic                    err;

  modport master (
    input  load_start, load_valid, load_data, load_last, run_start, halt_req,
           br_valid, br_target, inst_ready, ir_rdata,
    output load_ready, inst_valid, inst_data, inst_pc, ir_addr, ir_wdata, ir_we,
           prog_len, state, err
  );

  modport slave (
    output load_start, load_valid, load_data, load_last, run_start, halt_req,
           br_valid, br_target, inst_ready, ir_rdata,
    input  load_ready, inst_valid, inst_data, inst_pc, ir_addr, ir_wdata, ir_we,
           prog_len, state, err
  );
endinterface

// File: rtl/ir_fetch_ctrl.sv
// Loads a host program into the IR memory, then fetches it word by word to decode.
// Define IR_FETCH_LEN_CHECK_EN to halt with a sticky err when the PC leaves the loaded program.
module ir_fetch_ctrl #(
  parameter int IR_WIDTH     = 16,
  parameter int IR_MEM_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  ir_fetch_if.master bus
);
  localparam logic [IR_MEM_WIDTH:0] DEPTH = {1'b1, {IR_MEM_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FA   = 3'd2,
    FW   = 3'd3,
    FO   = 3'd4,
    HALT = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [IR_MEM_WIDTH-1:0] pc_q, pc_d;
  logic [IR_MEM_WIDTH-1:0] ir_addr_q, ir_addr_d;
  logic [IR_MEM_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [IR_MEM_WIDTH:0]   prog_len_q, prog_len_d;
  logic [IR_WIDTH-1:0]     ir_wdata_q, ir_wdata_d;
  logic [IR_WIDTH-1:0]     inst_data_q, inst_data_d;
  logic                    ir_we_q, ir_we_d;
  logic                    load_ready_q, load_ready_d;
  logic                    inst_valid_q, inst_valid_d;
  logic                    err_w;
  logic                    len_fault;

`ifdef IR_FETCH_LEN_CHECK_EN
  logic err_q, err_d;

  assign len_fault = ({1'b0, pc_q} >= prog_len_q);
  assign err_w     = err_q;

  always_comb begin
    err_d = err_q;
    if (state_d == LOAD) begin
      err_d = 1'b0;
    end else if (state_q == FA && state_d == HALT && !bus.halt_req) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign len_fault = 1'b0;
  assign err_w     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.load_start)                              state_d = LOAD;
        else if (bus.run_start && prog_len_q != '0)      state_d = FA;
      end
      // Once full, load_ready is low, so a valid last word only closes the load.
      LOAD: if (bus.load_valid && bus.load_last)         state_d = IDLE;
      FA:   state_d = (bus.halt_req || len_fault) ? HALT : FW;
      FW:   state_d = bus.halt_req ? HALT : FO;
      FO: begin
        if (bus.halt_req)                                state_d = HALT;
        else if (bus.inst_ready)                         state_d = FA;
      end
      HALT: begin
        if (bus.load_start)                              state_d = LOAD;
        else if (bus.run_start && !bus.halt_req && !err_w) state_d = FA;
      end
      default:                                           state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    prog_len_d   = prog_len_q;
    ir_addr_d    = ir_addr_q;
    ir_wdata_d   = ir_wdata_q;
    ir_we_d      = 1'b0;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    // prog_len doubles as the write pointer during a load.
    if (state_q != LOAD && state_d == LOAD) prog_len_d = '0;
    if (state_q == IDLE && state_d == FA)   pc_d = '0;
    case (state_q)
      LOAD: begin
        if (bus.load_valid && load_ready_q) begin
          ir_we_d    = 1'b1;
          ir_addr_d  = prog_len_q[IR_MEM_WIDTH-1:0];
          ir_wdata_d = bus.load_data;
          prog_len_d = prog_len_q + (IR_MEM_WIDTH+1)'(1);
        end
      end
      FW: begin
        if (state_d == FO) begin
          inst_data_d  = bus.ir_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
        end
      end
      FO: begin
        if (state_d != FO) inst_valid_d = 1'b0;
        if (state_d == FA) pc_d = bus.br_valid ? bus.br_target : pc_q + IR_MEM_WIDTH'(1);
      end
      default: ;
    endcase
    // The read is launched on entry to FA so its data is ready at the end of FW.
    if (state_d == FA) ir_addr_d = pc_d;
    load_ready_d = (state_d == LOAD) && (prog_len_d < DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      prog_len_q   <= '0;
      ir_addr_q    <= '0;
      ir_wdata_q   <= '0;
      ir_we_q      <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      prog_len_q   <= prog_len_d;
      ir_addr_q    <= ir_addr_d;
      ir_wdata_q   <= ir_wdata_d;
      ir_we_q      <= ir_we_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.load_ready = load_ready_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_data  = inst_data_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.ir_addr    = ir_addr_q;
  assign bus.ir_wdata   = ir_wdata_q;
  assign bus.ir_we      = ir_we_q;
  assign bus.prog_len   = prog_len_q;
  assign bus.err        = err_w;
endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Bench for ir_fetch_ctrl: IR memory model, behavioural reference model checked every
// cycle, directed program load/fetch/halt/branch sequence, then randomized traffic.
module tb_ir_fetch_ctrl;
  localparam int W     = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef IR_FETCH_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   testCount = 0;
  int   failCount = 0;
  logic haltLevel = 1'b0;

  ir_fetch_if #(.IR_WIDTH(W), .IR_MEM_WIDTH(AW)) bus ();

  ir_fetch_ctrl #(.IR_WIDTH(W), .IR_MEM_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // IR memory: registers its inputs each edge, writes one edge later, reads from the registered address.
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] memAddrQ  = '0;
  logic [W-1:0]  memWdataQ = '0;
  logic          memWeQ    = 1'b0;

  always @(posedge clk) begin
    memAddrQ  <= bus.ir_addr;
    memWdataQ <= bus.ir_wdata;
    memWeQ    <= bus.ir_we;
    if (memWeQ) mem[memAddrQ] <= memWdataQ;
  end
  assign bus.ir_rdata = mem[memAddrQ];

  // Reference model: mode 0 idle, 1 load, 2 running (mCnt = cycles into the fetch), 3 halted.
  int           mMode = 0, mCnt = 0, mPc = 0, mLen = 0, expAddr = 0;
  logic         mErr = 1'b0, expWe = 1'b0, expValid = 1'b0;
  logic [W-1:0] expWdata = '0, expInstData = '0;
  int           expInstPc = 0;
  logic [W-1:0] image [DEPTH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mMode = 0; mCnt = 0; mPc = 0; mLen = 0; expAddr = 0; mErr = 1'b0;
      expWe = 1'b0; expValid = 1'b0; expWdata = '0; expInstData = '0; expInstPc = 0;
    end else begin
      expWe = 1'b0;
      case (mMode)
        0: begin
          if (bus.load_start) begin
            mMode = 1; mLen = 0;
          end else if (bus.run_start && mLen > 0) begin
            mMode = 2; mCnt = 0; mPc = 0; expAddr = 0;
          end
        end
        1: begin
          if (bus.load_valid && mLen < DEPTH) begin
            expWe = 1'b1; expAddr = mLen; expWdata = bus.load_data;
            image[mLen] = bus.load_data;
            mLen++;
          end
          if (bus.load_valid && bus.load_last) mMode = 0;
        end
        2: begin
          if (bus.halt_req) begin
            mMode = 3; expValid = 1'b0;
          end else if (mCnt == 0) begin
            if (LEN_CHECK && mPc >= mLen) begin
              mMode = 3; mErr = 1'b1;
            end else mCnt = 1;
          end else if (mCnt == 1) begin
            mCnt = 2; expValid = 1'b1; expInstPc = mPc; expInstData = image[mPc];
          end else if (bus.inst_ready) begin
            expValid = 1'b0;
            mPc = bus.br_valid ? int'(bus.br_target) : (mPc + 1) % DEPTH;
            mCnt = 0; expAddr = mPc;
          end
        end
        default: begin
          if (bus.load_start) begin
            mMode = 1; mLen = 0; mErr = 1'b0;
          end else if (bus.run_start && !bus.halt_req && !mErr) begin
            mMode = 2; mCnt = 0; expAddr = mPc;
          end
        end
      endcase
    end
  end

  function automatic int expState();
    case (mMode)
      0:       return 0;
      1:       return 1;
      2:       return 2 + mCnt;
      default: return 5;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, all outputs are held against the model.
  always @(negedge clk) begin
    checkOutput("m_state",      32'(bus.state),      32'(expState()));
    checkOutput("m_inst_valid", 32'(bus.inst_valid), 32'(expValid));
    checkOutput("m_inst_pc",    32'(bus.inst_pc),    32'(expInstPc));
    checkOutput("m_inst_data",  32'(bus.inst_data),  32'(expInstData));
    checkOutput("m_load_ready", 32'(bus.load_ready), 32'(mMode == 1 && mLen < DEPTH));
    checkOutput("m_ir_we",      32'(bus.ir_we),      32'(expWe));
    checkOutput("m_ir_addr",    32'(bus.ir_addr),    32'(expAddr));
    checkOutput("m_ir_wdata",   32'(bus.ir_wdata),   32'(expWdata));
    checkOutput("m_prog_len",   32'(bus.prog_len),   32'(mLen));
    checkOutput("m_err",        32'(bus.err),        32'(mErr));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearInputs();
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    bus.run_start  = 1'b0; bus.halt_req   = 1'b0; bus.br_valid  = 1'b0; bus.br_target = '0;
    bus.inst_ready = 1'b0;
  endtask

  task automatic applyStimulus();
    if ($urandom_range(0, 99) < 4) haltLevel = ~haltLevel;
    bus.halt_req   = haltLevel;
    bus.load_start = ($urandom_range(0, 99) < 3);
    bus.run_start  = ($urandom_range(0, 99) < 8);
    bus.load_valid = ($urandom_range(0, 99) < 70);
    bus.load_last  = ($urandom_range(0, 99) < 8);
    bus.load_data  = 16'($urandom);
    bus.inst_ready = ($urandom_range(0, 99) < 60);
    bus.br_valid   = ($urandom_range(0, 99) < 25);
    bus.br_target  = 4'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic checkInst(input string name, input int pc, input logic [W-1:0] data);
    checkOutput({name, "_valid"}, 32'(bus.inst_valid), 32'd1);
    checkOutput({name, "_pc"},    32'(bus.inst_pc),    32'(pc));
    checkOutput({name, "_data"},  32'(bus.inst_data),  32'(data));
  endtask

  logic [W-1:0] words [3];

  initial begin
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]   = 16'hA500 | 16'(i);
      image[i] = 16'hA500 | 16'(i);
    end
    clearInputs();
    rst_n = 1'b0;
    tick();
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_prog_len", 32'(bus.prog_len), 32'd0);
    checkOutput("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    rst_n = 1'b1;

    // Three-word program load.
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    checkOutput("load_state", 32'(bus.state), 32'd1);
    checkOutput("load_ready", 32'(bus.load_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      bus.load_valid = 1'b1; bus.load_data = words[k]; bus.load_last = (k == 2);
      tick();
      checkOutput("load_we", 32'(bus.ir_we), 32'd1);
      checkOutput("load_addr", 32'(bus.ir_addr), 32'(k));
      checkOutput("load_wdata", 32'(bus.ir_wdata), 32'(words[k]));
    end
    clearInputs();
    checkOutput("load_len", 32'(bus.prog_len), 32'd3);
    checkOutput("load_done_state", 32'(bus.state), 32'd0);
    tick();
    checkOutput("load_done_ready", 32'(bus.load_ready), 32'd0);

    // Fetch from PC 0, then hold decode off for five cycles.
    bus.run_start = 1'b1;
    tick();
    bus.run_start = 1'b0;
    checkOutput("fa_state", 32'(bus.state), 32'd2);
    checkOutput("fa_addr", 32'(bus.ir_addr), 32'd0);
    tick();
    checkOutput("fw_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    checkInst("pc0", 0, 16'h1111);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkInst("hold", 0, 16'h1111);
      checkOutput("hold_addr", 32'(bus.ir_addr), 32'd0);
    end

    // Sequential fetch, then branch from PC 1 back to 0.
    bus.inst_ready = 1'b1;
    tick(3);
    checkInst("pc1", 1, 16'h2222);
    bus.br_valid = 1'b1; bus.br_target = 4'd0;
    tick();
    bus.br_valid = 1'b0;
    tick(2);
    checkInst("br", 0, 16'h1111);

    // Halt during FW at PC 1, then resume and see PC 1 again.
    tick(2);
    checkOutput("pre_halt_state", 32'(bus.state), 32'd3);
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    checkOutput("halt_state", 32'(bus.state), 32'd5);
    checkOutput("halt_valid", 32'(bus.inst_valid), 32'd0);
    bus.run_start = 1'b1;
    tick();
    bus.run_start = 1'b0;
    tick(2);
    checkInst("resume", 1, 16'h2222);
    tick(3);
    checkInst("pc2", 2, 16'h3333);

    // Past the end of the loaded program.
    tick(2);
`ifdef IR_FETCH_LEN_CHECK_EN
    checkOutput("bound_state", 32'(bus.state), 32'd5);
    checkOutput("bound_err", 32'(bus.err), 32'd1);
`else
    checkOutput("wrap_state", 32'(bus.state), 32'd3);
    tick();
    checkInst("pc3", 3, 16'hA503);
`endif
    bus.halt_req = 1'b1;
    tick();
    clearInputs();
    checkOutput("end_halt_state", 32'(bus.state), 32'd5);

    for (int n = 0; n < 800; n++) begin
      applyStimulus();
      tick();
    end

    // Async reset in the middle of a load.
    clearInputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1; bus.load_data = 16'hBEEF;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_state", 32'(bus.state), 32'd0);
    checkOutput("arst_prog_len", 32'(bus.prog_len), 32'd0);
    checkOutput("arst_we", 32'(bus.ir_we), 32'd0);
    checkOutput("arst_addr", 32'(bus.ir_addr), 32'd0);
    checkOutput("arst_wdata", 32'(bus.ir_wdata), 32'd0);
    checkOutput("arst_ready", 32'(bus.load_ready), 32'd0);
    clearInputs();
    tick(2);
    rst_n = 1'b1;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
